// File: rtl/tpu_pkg.sv
// Shared state type, job-size constants and requester-index helper for mmu_job_arbiter.
package tpu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_DONE,
    READ,
    RESP,
    DRAIN
  } arb_state_t;

  localparam int JOB_BYTES = 8;
  localparam int RES_WORDS = 4;

  // (base + off) mod n for requester indices; base, off < n <= 8
  function automatic logic [2:0] wrap_add(input logic [2:0] base, input logic [2:0] off,
                                          input int n);
    logic [3:0] sum;
    sum = {1'b0, base} + {1'b0, off};
    if (int'(sum) >= n) sum = sum - 4'(n);
    return sum[2:0];
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester at or after the pointer (wrapping); pointer moves past
// the last winner on an update strobe.
module rr_arbiter
  import tpu_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               update,
  input  logic [2:0]         last,
  output logic [2:0]         pick,
  output logic               pick_valid
);

  logic [2:0] ptr_reg;
  logic [2:0] cand;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    pick       = 3'd0;
    pick_valid = 1'b0;
    cand       = 3'd0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = wrap_add(ptr_reg, 3'(off), NUM_REQ);
      for (int r = 0; r < NUM_REQ; r++) begin
        if (req[r] && (cand == 3'(r))) begin
          pick       = cand;
          pick_valid = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_reg <= 3'd0;
    end else if (update) begin
      ptr_reg <= wrap_add(last, 3'd1, NUM_REQ);
    end
  end

endmodule

// File: rtl/mmu_job_arbiter.sv
// Shares one 2x2 matrix-multiply controller among NUM_REQ requesters, one job at a time.
// Optional MMU_ARB_TIMEOUT_EN bounds WAIT_DONE/DRAIN by TIMEOUT_CYCLES and pulses err on abort.
module mmu_job_arbiter
  import tpu_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  output logic [2:0]           rsp_id,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output logic                 load_en,
  output logic                 load_sel_ab,
  output logic [1:0]           load_index,
  output logic [7:0]           in_data,
  output logic                 output_en,
  output logic [1:0]           output_sel,
  input  logic [7:0]           out_data,
  input  logic                 done,
  output logic                 busy,
  output logic                 err
);

  arb_state_t state_reg, state_next;
  logic [2:0] grant_reg;
  logic [3:0] byte_cnt_reg;
  logic [1:0] word_cnt_reg;
  logic       load_en_reg;
  logic       load_sel_ab_reg;
  logic [1:0] load_index_reg;
  logic [7:0] in_data_reg;
  logic [7:0] res_reg [RES_WORDS];

  logic [2:0] pick;
  logic       pick_valid;
  logic       arb_update;
  logic [7:0] req_bytes [NUM_REQ];
  logic [7:0] sel_byte;
  logic       sel_valid;
  logic       sel_rsp_ready;
  logic       load_open;
  logic       req_fire;
  logic       rsp_fire;
  logic       timeout_hit;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .update    (arb_update),
    .last      (grant_reg),
    .pick      (pick),
    .pick_valid(pick_valid)
  );

  assign load_open = (state_reg == LOAD) && (byte_cnt_reg < 4'(JOB_BYTES));

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_bytes[gi] = req_data[8*gi +: 8];
    assign req_ready[gi] = load_open && (grant_reg == 3'(gi));
  end

  always_comb begin
    sel_byte      = 8'd0;
    sel_valid     = 1'b0;
    sel_rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_reg == 3'(i)) begin
        sel_byte      = req_bytes[i];
        sel_valid     = req_valid[i];
        sel_rsp_ready = rsp_ready[i];
      end
    end
  end

  assign req_fire = load_open && sel_valid;
  assign rsp_fire = (state_reg == RESP) && sel_rsp_ready;

`ifdef MMU_ARB_TIMEOUT_EN
  logic [15:0] tmo_cnt_reg;
  logic        err_reg;

  // Only fires when the normal exit condition is not also present this cycle.
  assign timeout_hit = (tmo_cnt_reg == 16'(TIMEOUT_CYCLES - 1)) &&
                       (((state_reg == WAIT_DONE) && !done) || ((state_reg == DRAIN) && done));
  assign err = err_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_reg <= 16'd0;
      err_reg     <= 1'b0;
    end else begin
      err_reg <= timeout_hit;
      if (state_next != state_reg) begin
        tmo_cnt_reg <= 16'd0;
      end else if ((state_reg == WAIT_DONE) || (state_reg == DRAIN)) begin
        tmo_cnt_reg <= tmo_cnt_reg + 16'd1;
      end
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign timeout_hit    = 1'b0;
  assign err            = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    arb_update = 1'b0;
    case (state_reg)
      IDLE:      if (pick_valid) state_next = LOAD;
      LOAD:      if (load_en_reg && (byte_cnt_reg == 4'(JOB_BYTES))) state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (done) begin
          state_next = READ;
        end else if (timeout_hit) begin
          state_next = IDLE;
          arb_update = 1'b1;
        end
      end
      READ:      if (word_cnt_reg == 2'(RES_WORDS - 1)) state_next = RESP;
      RESP:      if (rsp_fire && (word_cnt_reg == 2'(RES_WORDS - 1))) state_next = DRAIN;
      DRAIN: begin
        if (!done || timeout_hit) begin
          state_next = IDLE;
          arb_update = 1'b1;
        end
      end
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_reg       <= 3'd0;
      byte_cnt_reg    <= 4'd0;
      word_cnt_reg    <= 2'd0;
      load_en_reg     <= 1'b0;
      load_sel_ab_reg <= 1'b0;
      load_index_reg  <= 2'd0;
      in_data_reg     <= 8'd0;
      for (int i = 0; i < RES_WORDS; i++) res_reg[i] <= 8'd0;
    end else begin
      load_en_reg <= 1'b0;
      if (arb_update) grant_reg <= 3'd0;
      case (state_reg)
        IDLE: begin
          byte_cnt_reg <= 4'd0;
          word_cnt_reg <= 2'd0;
          if (pick_valid) grant_reg <= pick;
        end
        LOAD: begin
          // The controller write trails the handshake by one cycle.
          if (req_fire) begin
            load_en_reg     <= 1'b1;
            in_data_reg     <= sel_byte;
            load_sel_ab_reg <= byte_cnt_reg[2];
            load_index_reg  <= byte_cnt_reg[1:0];
            byte_cnt_reg    <= byte_cnt_reg + 4'd1;
          end
        end
        READ: begin
          res_reg[word_cnt_reg] <= out_data;
          word_cnt_reg          <= word_cnt_reg + 2'd1;
        end
        RESP: begin
          if (rsp_fire) word_cnt_reg <= word_cnt_reg + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_reg != IDLE);
  assign load_en     = load_en_reg;
  assign load_sel_ab = load_sel_ab_reg;
  assign load_index  = load_index_reg;
  assign in_data     = in_data_reg;
  assign output_en   = (state_reg == READ);
  assign output_sel  = output_en ? word_cnt_reg : 2'd0;
  assign rsp_valid   = (state_reg == RESP);
  assign rsp_data    = rsp_valid ? res_reg[word_cnt_reg] : 8'd0;
  assign rsp_id      = grant_reg;

endmodule

// File: tb/tb_mmu_job_arbiter.sv
// Directed bench for mmu_job_arbiter with a behavioural 2x2 multiply controller attached.
module tb_mmu_job_arbiter;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [7:0]     rsp_data;
  logic [2:0]     rsp_id;
  logic [N-1:0]   rsp_ready;
  logic           load_en;
  logic           load_sel_ab;
  logic [1:0]     load_index;
  logic [7:0]     in_data;
  logic           output_en;
  logic [1:0]     output_sel;
  logic [7:0]     out_data;
  logic           done;
  logic           busy;
  logic           err;

  always #5 clk = ~clk;

  mmu_job_arbiter #(
    .NUM_REQ(N)
`ifdef MMU_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(20)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .rsp_ready  (rsp_ready),
    .load_en    (load_en),
    .load_sel_ab(load_sel_ab),
    .load_index (load_index),
    .in_data    (in_data),
    .output_en  (output_en),
    .output_sel (output_sel),
    .out_data   (out_data),
    .done       (done),
    .busy       (busy),
    .err        (err)
  );

  // Controller model: stores A/B, raises done 3 cycles after the 8th load,
  // drops it 2 cycles after result 3 is read.
  logic [7:0]  ma [4];
  logic [7:0]  mb [4];
  int          m_loads, m_done_dly, m_clr_dly;
  bit          m_block;
  logic [15:0] mm_p;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loads <= 0; m_done_dly <= 0; m_clr_dly <= 0; done <= 1'b0;
      for (int i = 0; i < 4; i++) begin ma[i] <= 8'd0; mb[i] <= 8'd0; end
    end else begin
      if (load_en) begin
        if (load_sel_ab) mb[load_index] <= in_data;
        else ma[load_index] <= in_data;
        m_loads <= (m_loads == 7) ? 0 : m_loads + 1;
        if (m_loads == 7) m_done_dly <= 3;
      end
      if (m_done_dly > 0) begin
        m_done_dly <= m_done_dly - 1;
        if (m_done_dly == 1 && !m_block) done <= 1'b1;
      end
      if (output_en && output_sel == 2'd3) m_clr_dly <= 2;
      if (m_clr_dly > 0) begin
        m_clr_dly <= m_clr_dly - 1;
        if (m_clr_dly == 1) done <= 1'b0;
      end
    end
  end

  always_comb begin
    mm_p = 16'd0;
    case (output_sel)
      2'd0: mm_p = 16'(ma[0]) * 16'(mb[0]) + 16'(ma[1]) * 16'(mb[2]);
      2'd1: mm_p = 16'(ma[0]) * 16'(mb[1]) + 16'(ma[1]) * 16'(mb[3]);
      2'd2: mm_p = 16'(ma[2]) * 16'(mb[0]) + 16'(ma[3]) * 16'(mb[2]);
      default: mm_p = 16'(ma[2]) * 16'(mb[1]) + 16'(ma[3]) * 16'(mb[3]);
    endcase
  end
  assign out_data = output_en ? mm_p[7:0] : 8'd0;

  // Operands A0..A3,B0..B3 left to right; results C00,C01,C10,C11 left to right.
  logic [63:0] job_ops [5];
  logic [31:0] job_res [5];

  int n_checks = 0;
  int n_errors = 0;
  bit want [N];
  int idx [N];
  int cur_job [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic arm(input int i, input int j);
    cur_job[i] = j;
    idx[i]     = 0;
    want[i]    = 1'b1;
  endtask

  task automatic drive_reqs(input int rid, input bit paused);
    for (int i = 0; i < N; i++) begin
      req_valid[i]      = want[i] && !(paused && i == rid);
      req_data[8*i +: 8] = job_ops[cur_job[i]][63-8*(idx[i]%8) -: 8];
    end
  endtask

  task automatic take_handshakes(input logic [N-1:0] hs);
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        idx[i]++;
        if (idx[i] == 8) want[i] = 1'b0;
      end
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Runs one job for requester rid; optionally pauses its valid, stalls rsp_ready,
  // or returns early once abort_at bytes have been accepted.
  task automatic run_job(input int rid, input int pause_at, input int stall, input int abort_at);
    int         n_rsp, n_load, pause_left, stall_left;
    bit         seen_grant, fin;
    logic [N-1:0] hs;
    logic [7:0] got [4];
    logic [7:0] exp_b;
    n_rsp = 0; n_load = 0; pause_left = 0; stall_left = stall; seen_grant = 0; fin = 0;
    for (int k = 0; k < 4; k++) got[k] = 8'd0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      drive_reqs(rid, pause_left > 0);
      rsp_ready = (rsp_valid && stall_left > 0) ? '0 : '1;
      if (!seen_grant && req_ready != '0) begin
        check("grant", 32'(req_ready), 32'(1 << rid));
        seen_grant = 1;
      end
      if (load_en) begin
        if (n_load < 8) begin
          exp_b = job_ops[cur_job[rid]][63-8*n_load -: 8];
          check("ld_sel", 32'(load_sel_ab), 32'(n_load / 4));
          check("ld_index", 32'(load_index), 32'(n_load % 4));
          check("ld_data", 32'(in_data), 32'(exp_b));
        end
        n_load++;
      end
      if (rsp_valid && stall_left > 0) begin
        check("stall_data", 32'(rsp_data), 32'(job_res[cur_job[rid]][31-8*(n_rsp%4) -: 8]));
        stall_left--;
      end
      hs = req_valid & req_ready;
      if (rsp_valid && rsp_ready != '0) begin
        check("rsp_id", 32'(rsp_id), 32'(rid));
        if (n_rsp < 4) got[n_rsp] = rsp_data;
        n_rsp++;
      end
      if (pause_left > 0) pause_left--;
      step();
      take_handshakes(hs);
      if (hs[rid] && idx[rid] == pause_at) pause_left = 5;
      if (idx[rid] == abort_at) return;
      if (n_rsp >= 4 && !busy) fin = 1;
    end
    check("job_done", 32'(fin), 32'd1);
    check("n_load", 32'(n_load), 32'd8);
    check("n_rsp", 32'(n_rsp), 32'd4);
    for (int k = 0; k < 4; k++)
      check("rsp_data", 32'(got[k]), 32'(job_res[cur_job[rid]][31-8*k -: 8]));
    $display("job req=%0d results %0d %0d %0d %0d", rid, got[0], got[1], got[2], got[3]);
  endtask

  initial begin
    job_ops[0] = 64'h0102030405060708; job_res[0] = 32'h13162B32;  // 19,22,43,50
    job_ops[1] = 64'h0200000201020304; job_res[1] = 32'h02040608;  // 2*B
    job_ops[2] = 64'h0101010101020304; job_res[2] = 32'h04060406;
    job_ops[3] = 64'h0A141E2801000001; job_res[3] = 32'h0A141E28;  // A*I
    job_ops[4] = 64'hC801030002030000; job_res[4] = 32'h90580609;  // 400->144, 600->88
    for (int i = 0; i < N; i++) begin want[i] = 0; idx[i] = 0; cur_job[i] = 0; end
    m_block   = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_load_en", 32'(load_en), 32'd0);
    check("rst_output_en", 32'(output_en), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    rst_n = 1'b1;
    step();

    // Both requesting after reset: 0, then 1, then 0 again.
    arm(0, 0); arm(1, 1);
    run_job(0, 99, 0, 99);
    arm(0, 2);
    run_job(1, 99, 0, 99);
    arm(1, 3);
    run_job(0, 99, 0, 99);
    run_job(1, 99, 0, 99);

    // Requester 1 alone, valid dropped for 5 cycles after byte 3.
    arm(1, 0);
    run_job(1, 3, 0, 99);

    // Response stalled for 10 cycles.
    arm(0, 1);
    run_job(0, 99, 10, 99);

    // Reset after 5 of 8 bytes, then a fresh job from requester 1.
    arm(0, 2);
    run_job(0, 99, 0, 5);
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_req_ready", 32'(req_ready), 32'd0);
    check("arst_load_en", 32'(load_en), 32'd0);
    check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
    want[0] = 0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
    step();
    arm(1, 4);
    run_job(1, 99, 0, 99);

`ifdef MMU_ARB_TIMEOUT_EN
    begin : tmo_test
      int last_ld, err_at, err_n;
      logic [N-1:0] hs;
      last_ld = -1; err_at = -1; err_n = 0;
      m_block = 1;
      arm(0, 0);
      for (int cyc = 0; cyc < 80; cyc++) begin
        drive_reqs(0, 1'b0);
        rsp_ready = '1;
        if (load_en) last_ld = cyc;
        if (err) begin err_n++; err_at = cyc; end
        hs = req_valid & req_ready;
        step();
        take_handshakes(hs);
      end
      check("tmo_err_count", 32'(err_n), 32'd1);
      check("tmo_err_offset", 32'(err_at - last_ld), 32'd21);
      check("tmo_idle", 32'(busy), 32'd0);
      m_block = 0;
      arm(0, 1); arm(1, 3);
      run_job(1, 99, 0, 99);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mmu_job_arbiter.md
Name: mmu_job_arbiter

Overview:
Shares one matrix-multiply controller (the 2x2 systolic engine's load/readback front end) between NUM_REQ independent requesters. It grants one requester per job using round-robin priority and streams that requester's 8 operand bytes into the controller's load interface. It then waits for the controller's done, reads back the 4 result bytes, and returns them to the granted requester over a valid/ready response channel.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT_CYCLES, 255, max cycles in WAIT_DONE/DRAIN before abort (used only with MMU_ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester operand byte valid
req_data  in  8*NUM_REQ  per-requester operand byte; requester i uses bits [8i+7:8i]
req_ready  out  NUM_REQ  operand byte accepted; at most one bit high
rsp_valid  out  1  result byte valid
rsp_data  out  8  result byte
rsp_id  out  3  index of the requester that owns the response
rsp_ready  in  NUM_REQ  per-requester response ready; only bit rsp_id is observed
load_en  out  1  to controller: write in_data
load_sel_ab  out  1  to controller: 0=A, 1=B
load_index  out  2  to controller: element index
in_data  out  8  to controller: operand byte
output_en  out  1  to controller: read enable
output_sel  out  2  to controller: result select
out_data  in  8  from controller: selected result low byte (combinational on output_sel/output_en)
done  in  1  from controller: results available
busy  out  1  a job is in progress (state != IDLE)
err  out  1  one-cycle pulse on timeout abort (tied 0 without the feature)

Behaviour:
- Reset: all outputs 0; state IDLE; rr pointer 0; byte/word counters 0; result buffer cleared.
- IDLE: grant the first i, starting at the pointer and wrapping, with req_valid[i]=1. A lone requester wins regardless of the pointer. Register grant; next cycle enter LOAD. No grant if no req_valid bit is set.
- LOAD: req_ready[grant]=1 while byte count < 8. Each handshake (req_valid&req_ready) increments the count 0..7 in the order A0,A1,A2,A3,B0,B1,B2,B3.
  - The cycle after each handshake: load_en=1, in_data=byte, load_sel_ab=count[2], load_index=count[1:0].
  - Exactly one load_en per accepted byte.
  - If the requester drops req_valid, wait indefinitely.
  - After the 8th load_en, enter WAIT_DONE.
- WAIT_DONE: hold until done=1, then enter READ.
- READ: 4 consecutive cycles with output_en=1 and output_sel=0,1,2,3. On each edge, capture out_data into res[output_sel]. Then enter RESP.
- RESP: rsp_valid=1, rsp_data=res[k], rsp_id=grant for k=0..3. Advance on rsp_valid&rsp_ready[grant]. Hold data stable while stalled. After the 4th handshake, enter DRAIN.
- DRAIN: wait for done=0. Then set pointer=(grant+1) mod NUM_REQ, clear grant, return to IDLE.
- Best-case job latency: grant at 1 cycle, 8 loads, WAIT_DONE, 4 reads, 4 responses.
- req_ready is never high for a non-granted requester. New requests arriving mid-job wait; arbitration happens only in IDLE.
- Async reset mid-job: immediate return to reset values. Partially delivered bytes are discarded with no response.
- Counters and pointer wrap modulo their range. res holds only the low 8 bits (out_data width).

Optional Feature:
MMU_ARB_TIMEOUT_EN
- Defined: a cycle counter runs in WAIT_DONE and in DRAIN, and resets on state entry. On reaching TIMEOUT_CYCLES: pulse err for 1 cycle, send no response, advance the pointer past grant, and return to IDLE.
- Undefined: no counter is built; err is tied 0; waits are unbounded.

Decomposition:
- Package tpu_pkg:
  - arb_state_t enum {IDLE, LOAD, WAIT_DONE, READ, RESP, DRAIN}
  - constants JOB_BYTES=8, RES_WORDS=4
- One sub-module, rr_arbiter: a combinational wrapping priority pick from req_valid and the pointer, plus a registered pointer advanced on an update strobe.

Test Plan:
- Single requester 0 sends A=1,2,3,4 and B=5,6,7,8 with the real controller -> load_en pulses at index 0..3 with sel 0, then 0..3 with sel 1; rsp_data is 19,22,43,50 with rsp_id=0; busy returns to 0.
- req_valid=2'b11 in IDLE after reset -> grant 0 first, then 1. With both still requesting after that, the next grant is 0 (alternation).
- Requester 1 deasserts req_valid for 5 cycles after byte 3 -> no extra load_en; the job completes with correct results.
- rsp_ready[grant] low for 10 cycles during RESP -> rsp_valid and rsp_data stay stable; no byte is lost or duplicated.
- rst_n pulsed low after 5 of 8 bytes -> all outputs 0 immediately; the next job from requester 1 is granted and completes correctly.
- With MMU_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=20, done held 0 -> err pulses once at cycle 20 of WAIT_DONE, then IDLE, and the pointer advances.
